la_capture_sequencer: RTL and testbench

- Capture-side controller for the logic analyzer sample buffer.
- Sequences the write port of the dual-port BRAM: pre-trigger history ring, masked/external trigger detection with repeat skipping, post-trigger fill.
- Publishes the buffer start address and a finished flag for the bus-clock readout logic.
- Runs entirely in the cap_clk domain; CDC of finished/finished_ack is external.

---
 rtl/la_defines_pkg.sv | 25 ++
 rtl/la_trigger_match.sv | 30 +++
 rtl/la_capture_sequencer.sv | 166 ++++++++++++++++
 tb/tb_la_capture_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/la_defines_pkg.sv
// rtl/la_defines_pkg.sv - shared state encoding and buffer geometry helpers for the LA capture path
package la_defines;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE       = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    DONE      = 3'd4
  } la_state_t;

  function automatic int unsigned buf_samples(input int unsigned depth);
    return 32'd1 << depth;
  endfunction

  // Largest history that still leaves room for the trigger sample itself.
  function automatic int unsigned pre_clamp_max(input int unsigned depth);
    return buf_samples(depth) - 32'd1;
  endfunction

  function automatic int unsigned pre_count_width(input int unsigned depth);
    return depth + 32'd1;
  endfunction

endpackage

// File: rtl/la_trigger_match.sv
// rtl/la_trigger_match.sv - masked pattern compare against config latched at arm, ORed with external trigger
module la_trigger_match #(
  parameter int WIDTH = 32
) (
  input  logic             cap_clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] trigger,
  input  logic [WIDTH-1:0] trigger_mask,
  input  logic [WIDTH-1:0] cap_data,
  input  logic             ext_trigger,
  output logic             hit
);

  logic [WIDTH-1:0] trigger_l;
  logic [WIDTH-1:0] mask_l;

  always_ff @(posedge cap_clk) begin
    if (rst) begin
      trigger_l <= '0;
      mask_l    <= '0;
    end else if (load) begin
      trigger_l <= trigger;
      mask_l    <= trigger_mask;
    end
  end

  assign hit = (((cap_data ^ trigger_l) & mask_l) == '0) | ext_trigger;

endmodule

// File: rtl/la_capture_sequencer.sv
// rtl/la_capture_sequencer.sv - write-port sequencer: pre-trigger ring, trigger qualification, post fill
module la_capture_sequencer #(
  parameter int CAPTURE_WIDTH = 32,
  parameter int CAPTURE_DEPTH = 10
) (
  input  logic                     cap_clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     arm_strobe,
  input  logic [CAPTURE_WIDTH-1:0] trigger,
  input  logic [CAPTURE_WIDTH-1:0] trigger_mask,
  input  logic [CAPTURE_DEPTH:0]   pre_trigger_count,
  input  logic [31:0]              repeat_count,
  input  logic                     cap_external_trigger,
  input  logic [CAPTURE_WIDTH-1:0] cap_data,
  output logic                     wr_en,
  output logic [CAPTURE_DEPTH-1:0] wr_addr,
  output logic [CAPTURE_WIDTH-1:0] wr_data,
  output logic [CAPTURE_DEPTH-1:0] start_addr,
  output logic                     armed,
  output logic                     triggered,
  output logic                     finished,
  input  logic                     finished_ack
);

  import la_defines::*;

  localparam int PCW = pre_count_width(CAPTURE_DEPTH);
  localparam logic [CAPTURE_DEPTH-1:0] PRE_MAX = CAPTURE_DEPTH'(pre_clamp_max(CAPTURE_DEPTH));
  localparam logic [CAPTURE_DEPTH-1:0] ONE     = CAPTURE_DEPTH'(1);

  la_state_t state, state_nx;

  logic [CAPTURE_DEPTH-1:0] ptr, ptr_nx;
  logic [CAPTURE_DEPTH-1:0] pre_l, pre_nx;
  logic [CAPTURE_DEPTH-1:0] post_cnt, post_nx;
  logic [31:0]              skip, skip_nx;
  logic [CAPTURE_DEPTH-1:0] start_nx;
  logic [CAPTURE_DEPTH-1:0] wr_addr_nx;
  logic [CAPTURE_WIDTH-1:0] wr_data_nx;
  logic [CAPTURE_DEPTH-1:0] pre_clamped;
  logic [CAPTURE_DEPTH-1:0] post_init;
  logic                     wr_en_nx;
  logic                     do_write;
  logic                     load_cfg;
  logic                     hit;

  la_trigger_match #(
    .WIDTH (CAPTURE_WIDTH)
  ) u_match (
    .cap_clk      (cap_clk),
    .rst          (rst),
    .load         (load_cfg),
    .trigger      (trigger),
    .trigger_mask (trigger_mask),
    .cap_data     (cap_data),
    .ext_trigger  (cap_external_trigger),
    .hit          (hit)
  );

  assign pre_clamped = (pre_trigger_count > PCW'(PRE_MAX)) ? PRE_MAX
                                                           : pre_trigger_count[CAPTURE_DEPTH-1:0];
  assign post_init   = PRE_MAX - pre_l;

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    pre_nx     = pre_l;
    post_nx    = post_cnt;
    skip_nx    = skip;
    start_nx   = start_addr;
    wr_en_nx   = 1'b0;
    wr_addr_nx = wr_addr;
    wr_data_nx = wr_data;
    do_write   = 1'b0;
    load_cfg   = 1'b0;

    unique case (state)
      IDLE: begin
        if (arm_strobe && enable) begin
          load_cfg = 1'b1;
          pre_nx   = pre_clamped;
          skip_nx  = repeat_count;
          ptr_nx   = '0;
          state_nx = (pre_clamped != '0) ? PRE : WAIT_TRIG;
        end
      end
      PRE: begin
        if (!enable) begin
          state_nx = IDLE;
        end else begin
          do_write = 1'b1;
          if ((ptr + ONE) == pre_l) state_nx = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        if (!enable) begin
          state_nx = IDLE;
        end else begin
          do_write = 1'b1;
          if (hit) begin
            if (skip != 32'd0) begin
              skip_nx = skip - 32'd1;
            end else begin
              // The ring now holds pre history samples ending just before this one.
              start_nx = ptr - pre_l;
              post_nx  = post_init;
              state_nx = (post_init == '0) ? DONE : POST;
            end
          end
        end
      end
      POST: begin
        if (!enable) begin
          state_nx = IDLE;
        end else begin
          do_write = 1'b1;
          post_nx  = post_cnt - ONE;
          if (post_cnt == ONE) state_nx = DONE;
        end
      end
      DONE: begin
        if (finished_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (do_write) begin
      wr_en_nx   = 1'b1;
      wr_addr_nx = ptr;
      wr_data_nx = cap_data;
      ptr_nx     = ptr + ONE;
    end
  end

  always_ff @(posedge cap_clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      pre_l      <= '0;
      post_cnt   <= '0;
      skip       <= '0;
      start_addr <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      armed      <= 1'b0;
      triggered  <= 1'b0;
      finished   <= 1'b0;
    end else begin
      state      <= state_nx;
      ptr        <= ptr_nx;
      pre_l      <= pre_nx;
      post_cnt   <= post_nx;
      skip       <= skip_nx;
      start_addr <= start_nx;
      wr_en      <= wr_en_nx;
      wr_addr    <= wr_addr_nx;
      wr_data    <= wr_data_nx;
      armed      <= (state_nx == PRE) || (state_nx == WAIT_TRIG) || (state_nx == POST);
      triggered  <= (state_nx == POST) || (state_nx == DONE);
      finished   <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_la_capture_sequencer.sv
// tb/tb_la_capture_sequencer.sv - scoreboard bench for la_capture_sequencer (N=16, 8-bit samples)
module tb_la_capture_sequencer;

  localparam int W = 8;
  localparam int D = 4;

  logic         cap_clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         arm_strobe;
  logic [W-1:0] trigger;
  logic [W-1:0] trigger_mask;
  logic [D:0]   pre_trigger_count;
  logic [31:0]  repeat_count;
  logic         cap_external_trigger;
  logic [W-1:0] cap_data;
  logic         wr_en;
  logic [D-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic [D-1:0] start_addr;
  logic         armed;
  logic         triggered;
  logic         finished;
  logic         finished_ack;

  typedef struct {
    logic [D-1:0] addr;
    logic [W-1:0] data;
  } wr_t;

  wr_t          exp_q[$];
  logic [D-1:0] exp_addr;
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 cap_clk = ~cap_clk;

  la_capture_sequencer #(
    .CAPTURE_WIDTH (W),
    .CAPTURE_DEPTH (D)
  ) dut (
    .cap_clk              (cap_clk),
    .rst                  (rst),
    .enable               (enable),
    .arm_strobe           (arm_strobe),
    .trigger              (trigger),
    .trigger_mask         (trigger_mask),
    .pre_trigger_count    (pre_trigger_count),
    .repeat_count         (repeat_count),
    .cap_external_trigger (cap_external_trigger),
    .cap_data             (cap_data),
    .wr_en                (wr_en),
    .wr_addr              (wr_addr),
    .wr_data              (wr_data),
    .start_addr           (start_addr),
    .armed                (armed),
    .triggered            (triggered),
    .finished             (finished),
    .finished_ack         (finished_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every observed write must be the next one the stimulus predicted.
  always @(posedge cap_clk) begin
    #1;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
  end

  task automatic step();
    @(negedge cap_clk);
  endtask

  task automatic arm(input logic [W-1:0] t, input logic [W-1:0] m, input logic [D:0] p,
                     input logic [31:0] r);
    trigger           = t;
    trigger_mask      = m;
    pre_trigger_count = p;
    repeat_count      = r;
    enable            = 1'b1;
    arm_strobe        = 1'b1;
    step();
    arm_strobe = 1'b0;
    exp_addr   = '0;
  endtask

  task automatic feed(input logic [W-1:0] d, input logic ext, input bit expect_wr);
    cap_data             = d;
    cap_external_trigger = ext;
    if (expect_wr) begin
      exp_q.push_back('{exp_addr, d});
      exp_addr = exp_addr + 1'b1;
    end
    step();
    cap_external_trigger = 1'b0;
  endtask

  task automatic ack();
    finished_ack = 1'b1;
    step();
    finished_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; arm_strobe = 1'b0; trigger = '0; trigger_mask = '0;
    pre_trigger_count = '0; repeat_count = '0; cap_external_trigger = 1'b0;
    cap_data = '0; finished_ack = 1'b0; exp_addr = '0;
    step(); step();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_flags", {29'd0, armed, triggered, finished}, 0);
    chk("rst_start", 32'(start_addr), 0);
    rst = 1'b0;
    step();

    // arm_strobe without enable is ignored
    arm_strobe = 1'b1; enable = 1'b0; step(); arm_strobe = 1'b0;
    chk("arm_no_en", 32'(armed), 0);

    // 1: pre=0, trigger on sixth sample
    arm(8'hA5, 8'hFF, 5'd0, 32'd0);
    chk("s1_armed", 32'(armed), 1);
    for (int i = 0; i < 5; i++) feed(8'(i), 1'b0, 1'b1);
    chk("s1_not_trig", 32'(triggered), 0);
    feed(8'hA5, 1'b0, 1'b1);
    chk("s1_trig", 32'(triggered), 1);
    for (int i = 0; i < 15; i++) feed(8'(8'h40 + i), 1'b0, 1'b1);
    chk("s1_finished", 32'(finished), 1);
    chk("s1_start", 32'(start_addr), 5);
    chk("s1_armed_off", 32'(armed), 0);
    feed(8'h00, 1'b0, 1'b0);
    chk("s1_done_hold", 32'(finished), 1);
    ack();
    chk("s1_ack_fin", 32'(finished), 0);
    chk("s1_ack_trig", 32'(triggered), 0);

    // 2: pre=4, masked match in PRE ignored, match at index 9
    arm(8'h03, 8'h0F, 5'd4, 32'd0);
    for (int i = 0; i < 9; i++) feed((i == 2) ? 8'hF3 : 8'(i << 4), 1'b0, 1'b1);
    chk("s2_pre_ignored", 32'(triggered), 0);
    feed(8'h83, 1'b0, 1'b1);
    chk("s2_trig", 32'(triggered), 1);
    chk("s2_start", 32'(start_addr), 5);
    for (int i = 0; i < 11; i++) feed(8'(8'hC0 + i), 1'b0, 1'b1);
    chk("s2_finished", 32'(finished), 1);
    ack();

    // 3: repeat=2, external trigger accepted on third pulse
    arm(8'h00, 8'hFF, 5'd0, 32'd2);
    for (int i = 0; i < 11; i++) begin
      feed(8'(8'h11 + i), (i == 3 || i == 6 || i == 10), 1'b1);
      if (i == 3 || i == 6) chk("s3_skip", 32'(triggered), 0);
    end
    chk("s3_trig", 32'(triggered), 1);
    chk("s3_start", 32'(start_addr), 10);
    for (int i = 0; i < 15; i++) feed(8'(8'h20 + i), 1'b0, 1'b1);
    chk("s3_finished", 32'(finished), 1);
    ack();

    // 4: pre 20 clamps to 15, no POST phase
    arm(8'h77, 8'hFF, 5'd20, 32'd0);
    for (int i = 0; i < 20; i++) feed(8'(i + 1), 1'b0, 1'b1);
    chk("s4_wait", 32'(triggered), 0);
    feed(8'h77, 1'b0, 1'b1);
    chk("s4_finished", 32'(finished), 1);
    chk("s4_start", 32'(start_addr), 5);
    feed(8'h77, 1'b0, 1'b0);
    ack();

    // 5: abort in third POST cycle, then re-arm from address 0
    arm(8'h3C, 8'hFF, 5'd0, 32'd0);
    feed(8'h3C, 1'b0, 1'b1);
    feed(8'h01, 1'b0, 1'b1);
    feed(8'h02, 1'b0, 1'b1);
    enable = 1'b0;
    feed(8'h03, 1'b0, 1'b0);
    chk("s5_wr_en", 32'(wr_en), 0);
    chk("s5_flags", {29'd0, armed, triggered, finished}, 0);
    chk("s5_start", 32'(start_addr), 0);
    step(); step();
    chk("s5_no_fin", 32'(finished), 0);
    arm(8'h3C, 8'hFF, 5'd0, 32'd0);
    feed(8'h55, 1'b0, 1'b1);
    feed(8'h3C, 1'b0, 1'b1);
    feed(8'h66, 1'b0, 1'b1);
    feed(8'h67, 1'b0, 1'b1);

    // rst mid-POST: no write that cycle, everything back to zero
    rst = 1'b1;
    feed(8'h68, 1'b0, 1'b0);
    chk("rst2_wr_en", 32'(wr_en), 0);
    chk("rst2_addr", 32'(wr_addr), 0);
    chk("rst2_flags", {29'd0, armed, triggered, finished}, 0);
    chk("rst2_start", 32'(start_addr), 0);
    rst = 1'b0;
    step();

    // 6: ack and arm together in DONE; a later lone arm starts a capture
    arm(8'h99, 8'hFF, 5'd15, 32'd0);
    for (int i = 0; i < 15; i++) feed(8'(i), 1'b0, 1'b1);
    feed(8'h99, 1'b0, 1'b1);
    chk("s6_finished", 32'(finished), 1);
    chk("s6_start", 32'(start_addr), 0);
    finished_ack = 1'b1; arm_strobe = 1'b1;
    step();
    finished_ack = 1'b0; arm_strobe = 1'b0;
    chk("s6_ack_arm", {29'd0, armed, triggered, finished}, 0);
    feed(8'h99, 1'b0, 1'b0);
    chk("s6_idle", 32'(armed), 0);
    arm(8'h99, 8'hFF, 5'd0, 32'd0);
    chk("s6_rearm", 32'(armed), 1);
    feed(8'h99, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) feed(8'(8'hE0 + i), 1'b0, 1'b1);
    chk("s6_finished2", 32'(finished), 1);
    chk("s6_start2", 32'(start_addr), 0);
    ack();

    step();
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
